// File: rtl/rv_reg_slice.sv
// rtl/rv_reg_slice.sv - valid/ready register slice with bypass, forward, skid and full variants
module rv_reg_slice #(
  parameter int WD   = 4,
  parameter int MODE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [WD-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [WD-1:0] m_data,
  output logic [1:0]    occ
);

  generate
    if (MODE == 0) begin : g_bypass
      assign m_valid = s_valid;
      assign m_data  = s_data;
      assign s_ready = m_ready;
      assign occ     = 2'd0;
    end else if (MODE == 1) begin : g_forward
      logic          out_v_q;
      logic [WD-1:0] out_data_q;

      assign s_ready = ~out_v_q | m_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_v_q    <= 1'b0;
          out_data_q <= '0;
        end else if (s_valid && s_ready) begin
          out_v_q    <= 1'b1;
          out_data_q <= s_data;
        end else if (m_ready) begin
          out_v_q    <= 1'b0;
        end
      end

      assign m_valid = out_v_q;
      assign m_data  = out_data_q;
      assign occ     = {1'b0, out_v_q};
    end else if (MODE == 2) begin : g_skid
      logic          skid_v_q, skid_v_d;
      logic [WD-1:0] skid_data_q, skid_data_d;
      logic          s_ready_q, s_ready_d;
      logic          load;

      // A beat accepted while downstream stalls is parked so the registered s_ready can lag a cycle.
      assign load = s_valid & s_ready_q & ~m_ready;

      always_comb begin
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (load) begin
          skid_v_d    = 1'b1;
          skid_data_d = s_data;
        end else if (m_ready && skid_v_q) begin
          skid_v_d    = 1'b0;
        end
        s_ready_d = m_ready | (~skid_v_q & ~load);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          skid_v_q    <= 1'b0;
          skid_data_q <= '0;
          s_ready_q   <= 1'b1;
        end else begin
          skid_v_q    <= skid_v_d;
          skid_data_q <= skid_data_d;
          s_ready_q   <= s_ready_d;
        end
      end

      assign s_ready = s_ready_q;
      assign m_valid = skid_v_q | s_valid;
      assign m_data  = skid_v_q ? skid_data_q : s_data;
      assign occ     = {1'b0, skid_v_q};
    end else if (MODE == 3) begin : g_full
      logic          main_v_q, main_v_d;
      logic [WD-1:0] main_data_q, main_data_d;
      logic          skid_v_q, skid_v_d;
      logic [WD-1:0] skid_data_q, skid_data_d;
      logic          s_ready_q, s_ready_d;
      logic          accept, drain;

      assign accept = s_valid & s_ready_q;
      assign drain  = main_v_q & m_ready;

      // s_ready is low only when both entries are full, so accept and a pending skid never coincide.
      always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (drain) begin
          if (skid_v_q) begin
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
          end else if (accept) begin
            main_data_d = s_data;
          end else begin
            main_v_d    = 1'b0;
          end
        end else if (accept) begin
          if (!main_v_q) begin
            main_v_d    = 1'b1;
            main_data_d = s_data;
          end else begin
            skid_v_d    = 1'b1;
            skid_data_d = s_data;
          end
        end
        s_ready_d = ~(main_v_d & skid_v_d);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          main_v_q    <= 1'b0;
          main_data_q <= '0;
          skid_v_q    <= 1'b0;
          skid_data_q <= '0;
          s_ready_q   <= 1'b1;
        end else begin
          main_v_q    <= main_v_d;
          main_data_q <= main_data_d;
          skid_v_q    <= skid_v_d;
          skid_data_q <= skid_data_d;
          s_ready_q   <= s_ready_d;
        end
      end

      assign s_ready = s_ready_q;
      assign m_valid = main_v_q;
      assign m_data  = main_data_q;
      assign occ     = {1'b0, main_v_q} + {1'b0, skid_v_q};
    end else begin : g_bad_mode
      $error("rv_reg_slice: MODE must be 0, 1, 2 or 3");
    end
  endgenerate

endmodule

// File: doc/rv_reg_slice.md
Name: rv_reg_slice

Overview:
- Parametrised valid/ready register slice for pipeline timing closure on handshake buses.
- Generalises the single-mode "ready registered" slice.
- A compile-time MODE selects one of four variants: bypass, forward (valid/data registered), backward (ready registered via skid entry), or full (all three registered).
- Inserted between any producer/consumer pair on the stream fabric; lossless, order-preserving, full throughput in every mode.

Parameters:
- WD, 4, payload width in bits (>=1).
- MODE, 2, 0=bypass, 1=forward, 2=backward (skid), 3=full; any other value is an elaboration error.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_valid  input  1  upstream data valid.
- s_ready  output  1  slice can accept upstream beat.
- s_data  input  WD  upstream payload.
- m_valid  output  1  downstream data valid.
- m_ready  input  1  downstream accepts beat.
- m_data  output  WD  downstream payload.
- occ  output  2  number of beats currently stored in slice (0..2).

Behaviour:
- Transfer occurs on a clock edge where valid & ready are both 1 on that side. Beats leave in arrival order, never dropped or duplicated.
- While m_valid=1 & m_ready=0: m_valid and m_data hold stable until accepted (all modes except MODE 0, where they follow upstream).
- Reset (all modes 1-3): s_ready=1 in the cycle after rst; m_valid=0; occ=0; stored beats discarded. Data registers are reset to 0.
- Reset asserted mid-stream flushes contents. Upstream must re-present any unaccepted beat.
- MODE 0:
  - m_valid=s_valid, m_data=s_data, s_ready=m_ready, all combinational.
  - occ=0 constant; no state.
- MODE 1 (forward):
  - One output register (out_v, out_d); m_valid=out_v, m_data=out_d; latency 1.
  - s_ready = ~out_v | m_ready (combinational from m_ready only).
  - On edge: if s_valid & s_ready, load s_data and set out_v=1. Else if m_ready, clear out_v.
  - occ=out_v.
- MODE 2 (backward/skid):
  - s_ready is a flop. Data path is combinational when skid is empty; latency 0.
  - m_valid = skid_v | s_valid; m_data = skid_v ? skid_d : s_data.
  - Skid loads when s_valid & s_ready & ~m_ready. Skid clears when m_ready & skid_v.
  - s_ready_next = m_ready | (~skid_v & ~load).
  - Never loses the beat accepted in the cycle s_ready drops.
  - occ=skid_v.
- MODE 3 (full):
  - Main register plus skid register; s_ready, m_valid and m_data are all flop outputs; latency 1.
  - s_ready_next = ~(occ_next==2).
  - Upstream beat goes to main if main is empty or main is being drained. Otherwise it goes to skid.
  - On main drain with skid_v: skid moves to main in the same edge.
  - Simultaneous accept+drain keeps occ unchanged.
  - occ = main_v + skid_v.
  - Sustained 1 beat/cycle with m_ready=1 constant.
- Must hold in all modes: occ never exceeds 2; no accept while s_ready=0. The bench flags any accept when s_ready=0 as an upstream protocol error. The slice ignores s_data in that case.

Test Plan:
- MODE=1, WD=8, send 0x01..0x10 with m_ready=1 constantly -> m_data 0x01..0x10 one cycle after each accept, 16 beats in 17 cycles, occ<=1.
- MODE=2, stream 0xA,0xB,0xC. Drop m_ready for 3 cycles after 0xA accepted -> 0xB held in skid, s_ready=0 from next cycle, occ=1. On m_ready=1: 0xB then 0xC delivered, no loss.
- MODE=3, m_ready=0 with s_valid=1 for 4 cycles -> exactly 2 beats accepted, occ=2, s_ready=0. Release m_ready -> both out in order, then streaming resumes at full rate.
- Random valid/ready toggling (30%/70%) for 1000 beats in each MODE 0-3, WD=4 -> scoreboard matches in order; m_data stable while stalled; no accept when s_ready=0.
- MODE=3 with occ=2, assert rst for 1 cycle -> next cycle m_valid=0, occ=0, s_ready=1. The first beat after reset is delivered with value intact.
- MODE=0, WD=16 -> m_valid/m_data/s_ready equal inputs combinationally in the same cycle, occ=0 throughout.
